// File: rtl/rob_unit_mp_if.sv
// Bus bundle for rob_unit_mp: dispatch, writeback, commit and head/occupancy status.
// master is the pipeline side that drives requests; slave is the reorder buffer itself.
interface rob_unit_mp_if #(
  parameter int ROB_ADDR_SIZE  = 5,
  parameter int DEST_ADDR_SIZE = 4,
  parameter int INS_TYPE_SIZE  = 2,
  parameter int WB_PORTS       = 2
) ();
  logic                              flush;
  logic                              add_entry;
  logic [DEST_ADDR_SIZE-1:0]         entry_dest_addr;
  logic [INS_TYPE_SIZE-1:0]          entry_ins_type;
  logic                              entry_finished;
  logic [WB_PORTS-1:0]               wb_valid;
  logic [WB_PORTS*ROB_ADDR_SIZE-1:0] wb_rob_id;
  logic [WB_PORTS-1:0]               wb_exception;
  logic                              commit_head;

  logic [ROB_ADDR_SIZE-1:0]          head_id;
  logic [ROB_ADDR_SIZE-1:0]          tail_id;
  logic                              head_valid;
  logic                              head_finished;
  logic                              head_exception;
  logic [DEST_ADDR_SIZE-1:0]         head_dest_addr;
  logic [INS_TYPE_SIZE-1:0]          head_ins_type;
  logic [ROB_ADDR_SIZE:0]            count;
  logic                              is_full;
  logic                              is_empty;

  modport master (
    output flush, add_entry, entry_dest_addr, entry_ins_type, entry_finished,
           wb_valid, wb_rob_id, wb_exception, commit_head,
    input  head_id, tail_id, head_valid, head_finished, head_exception,
           head_dest_addr, head_ins_type, count, is_full, is_empty
  );

  modport slave (
    input  flush, add_entry, entry_dest_addr, entry_ins_type, entry_finished,
           wb_valid, wb_rob_id, wb_exception, commit_head,
    output head_id, tail_id, head_valid, head_finished, head_exception,
           head_dest_addr, head_ins_type, count, is_full, is_empty
  );
endinterface

// File: rtl/rob_unit_mp.sv
// Multi-writeback reorder buffer: one allocate per cycle, WB_PORTS finish reports, in-order commit.
// Head outputs are zero-latency reads; adds while full are dropped, unfinished-head commits ignored.
module rob_unit_mp #(
  parameter int ROB_ADDR_SIZE  = 5,
  parameter int DEST_ADDR_SIZE = 4,
  parameter int INS_TYPE_SIZE  = 2,
  parameter int WB_PORTS       = 2
) (
  input logic          clk,
  input logic          reset,
  rob_unit_mp_if.slave bus
);
  localparam int ROB_SIZE = 1 << ROB_ADDR_SIZE;

  typedef struct packed {
    logic                      valid;
    logic                      finished;
    logic                      exception;
    logic [INS_TYPE_SIZE-1:0]  ins_type;
    logic [DEST_ADDR_SIZE-1:0] dest;
  } entry_t;

  entry_t                   rob [ROB_SIZE];
  logic [ROB_ADDR_SIZE-1:0] head_q;
  logic [ROB_ADDR_SIZE-1:0] tail_q;
  logic [ROB_ADDR_SIZE:0]   count_q;

  entry_t                   head_e;
  logic                     full;
  logic                     empty;
  logic                     add_acc;
  logic                     commit_acc;

  logic [ROB_SIZE-1:0]      wb_fin;
  logic [ROB_SIZE-1:0]      wb_exc;
  logic [ROB_ADDR_SIZE-1:0] wb_id;

  assign head_e     = rob[head_q];
  assign full       = (count_q == (ROB_ADDR_SIZE+1)'(ROB_SIZE));
  assign empty      = (count_q == '0);
  // Full is the registered view, so a same-cycle commit never makes room for an add.
  assign add_acc    = bus.add_entry && !full;
  assign commit_acc = bus.commit_head && head_e.valid && head_e.finished;

  // Fold all writeback ports into per-entry finish/exception strobes; hits on one id OR together.
  always_comb begin
    wb_fin = '0;
    wb_exc = '0;
    wb_id  = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      wb_id = bus.wb_rob_id[p*ROB_ADDR_SIZE +: ROB_ADDR_SIZE];
      if (bus.wb_valid[p]) begin
        wb_fin[wb_id] = 1'b1;
        wb_exc[wb_id] = wb_exc[wb_id] | bus.wb_exception[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        rob[i] <= '0;
      end
    end else begin
      // Only entries already valid before this edge take writeback; a slot being allocated does not.
      for (int i = 0; i < ROB_SIZE; i++) begin
        if (rob[i].valid && wb_fin[i]) begin
          rob[i].finished  <= 1'b1;
          rob[i].exception <= rob[i].exception | wb_exc[i];
        end
      end
      if (add_acc) begin
        rob[tail_q].valid     <= 1'b1;
        rob[tail_q].finished  <= bus.entry_finished;
        rob[tail_q].exception <= 1'b0;
        rob[tail_q].ins_type  <= bus.entry_ins_type;
        rob[tail_q].dest      <= bus.entry_dest_addr;
        tail_q                <= tail_q + 1'b1;
      end
      if (commit_acc) begin
        rob[head_q].valid <= 1'b0;
        head_q            <= head_q + 1'b1;
      end
      count_q <= count_q + (ROB_ADDR_SIZE+1)'(add_acc) - (ROB_ADDR_SIZE+1)'(commit_acc);
    end
  end

  assign bus.head_id        = head_q;
  assign bus.tail_id        = tail_q;
  assign bus.head_valid     = head_e.valid;
  assign bus.head_finished  = head_e.valid & head_e.finished;
  assign bus.head_exception = head_e.valid & head_e.exception;
  assign bus.head_dest_addr = head_e.dest;
  assign bus.head_ins_type  = head_e.ins_type;
  assign bus.count          = count_q;
  assign bus.is_full        = full;
  assign bus.is_empty       = empty;
endmodule

// File: tb/tb_rob_unit_mp.sv
// Directed bench for rob_unit_mp: an in-order queue model checked every cycle plus literal checkpoints.
module tb_rob_unit_mp;
  localparam int RAS  = 5;
  localparam int RSZ  = 32;
  localparam int DAS  = 4;
  localparam int ITS  = 2;
  localparam int WBP  = 2;

  logic clk;
  logic reset;
  int   vectors;
  int   fails;
  bit   started;

  rob_unit_mp_if #(.ROB_ADDR_SIZE(RAS), .DEST_ADDR_SIZE(DAS),
                   .INS_TYPE_SIZE(ITS), .WB_PORTS(WBP)) bus ();

  rob_unit_mp #(.ROB_ADDR_SIZE(RAS), .DEST_ADDR_SIZE(DAS),
                .INS_TYPE_SIZE(ITS), .WB_PORTS(WBP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: occupied entries in program order, oldest first.
  typedef struct {
    int         id;
    logic [3:0] dest;
    logic [1:0] typ;
    bit         fin;
    bit         exc;
  } ment_t;

  ment_t mq[$];
  int    m_head;
  int    m_tail_id;
  bit    m_add_acc;
  bit    m_commit_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    started = 1'b1;
    if (reset || bus.flush) begin
      mq.delete();
      m_head = 0;
    end else begin
      m_tail_id    = (m_head + mq.size()) % RSZ;
      m_add_acc    = bus.add_entry && (mq.size() < RSZ);
      m_commit_acc = bus.commit_head && (mq.size() > 0) && mq[0].fin;
      for (int p = 0; p < WBP; p++) begin
        if (bus.wb_valid[p]) begin
          for (int k = 0; k < mq.size(); k++) begin
            if (mq[k].id == int'(bus.wb_rob_id[p*RAS +: RAS])) begin
              mq[k].fin = 1'b1;
              if (bus.wb_exception[p]) mq[k].exc = 1'b1;
            end
          end
        end
      end
      if (m_commit_acc) begin
        void'(mq.pop_front());
        m_head = (m_head + 1) % RSZ;
      end
      if (m_add_acc)
        mq.push_back('{m_tail_id, bus.entry_dest_addr, bus.entry_ins_type, bus.entry_finished, 1'b0});
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("head_id",    32'(bus.head_id),    32'(m_head));
      chk("tail_id",    32'(bus.tail_id),    32'((m_head + mq.size()) % RSZ));
      chk("count",      32'(bus.count),      32'(mq.size()));
      chk("is_full",    32'(bus.is_full),    32'(mq.size() == RSZ));
      chk("is_empty",   32'(bus.is_empty),   32'(mq.size() == 0));
      chk("head_valid", 32'(bus.head_valid), 32'(mq.size() > 0));
      chk("head_finished",  32'(bus.head_finished),  (mq.size() > 0) ? 32'(mq[0].fin) : 32'd0);
      chk("head_exception", 32'(bus.head_exception), (mq.size() > 0) ? 32'(mq[0].exc) : 32'd0);
      if (mq.size() > 0) begin
        chk("head_dest_addr", 32'(bus.head_dest_addr), 32'(mq[0].dest));
        chk("head_ins_type",  32'(bus.head_ins_type),  32'(mq[0].typ));
      end
    end
  end

  task automatic idle();
    bus.flush           = 1'b0;
    bus.add_entry       = 1'b0;
    bus.entry_dest_addr = '0;
    bus.entry_ins_type  = '0;
    bus.entry_finished  = 1'b0;
    bus.wb_valid        = '0;
    bus.wb_rob_id       = '0;
    bus.wb_exception    = '0;
    bus.commit_head     = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic add(input logic [3:0] d, input logic [1:0] t, input bit f);
    bus.add_entry       = 1'b1;
    bus.entry_dest_addr = d;
    bus.entry_ins_type  = t;
    bus.entry_finished  = f;
  endtask

  task automatic wb(input int p, input logic [4:0] id, input bit e);
    bus.wb_valid[p]             = 1'b1;
    bus.wb_rob_id[p*RAS +: RAS] = id;
    bus.wb_exception[p]         = e;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    vectors = 0;
    fails   = 0;
    started = 1'b0;
    idle();
    reset = 1'b1;

    // Reset state
    do_reset();
    chk("rst head_id", 32'(bus.head_id), 0);
    chk("rst tail_id", 32'(bus.tail_id), 0);
    chk("rst count", 32'(bus.count), 0);
    chk("rst is_empty", 32'(bus.is_empty), 1);
    chk("rst is_full", 32'(bus.is_full), 0);
    chk("rst head_valid", 32'(bus.head_valid), 0);
    chk("rst head_dest", 32'(bus.head_dest_addr), 0);
    chk("rst head_type", 32'(bus.head_ins_type), 0);

    // Fill to 32, then a dropped 33rd add
    for (int i = 0; i < RSZ; i++) begin
      idle(); add(4'(i), 2'(i), 1'b0); tick();
      chk("fill tail_id", 32'(bus.tail_id), 32'((i + 1) % RSZ));
    end
    chk("fill count", 32'(bus.count), 32);
    chk("fill is_full", 32'(bus.is_full), 1);
    idle(); add(4'hF, 2'd3, 1'b1); tick();
    chk("drop tail_id", 32'(bus.tail_id), 0);
    chk("drop count", 32'(bus.count), 32);

    // Exception writeback on port 1, then commit
    do_reset();
    idle(); add(4'd7, 2'd2, 1'b0); tick();
    idle(); wb(1, 5'd0, 1'b1); tick();
    chk("exc head_finished", 32'(bus.head_finished), 1);
    chk("exc head_exception", 32'(bus.head_exception), 1);
    chk("exc count before", 32'(bus.count), 1);
    idle(); bus.commit_head = 1'b1; tick();
    chk("exc count after", 32'(bus.count), 0);
    chk("exc is_empty", 32'(bus.is_empty), 1);
    chk("exc head_id", 32'(bus.head_id), 1);

    // wb on allocating entry ignored; unfinished commit ignored; dual-port wb same id
    do_reset();
    idle(); add(4'd3, 2'd1, 1'b0); wb(0, 5'd0, 1'b1); tick();
    chk("alloc wb ignored", 32'(bus.head_finished), 0);
    idle(); bus.commit_head = 1'b1; tick();
    chk("unfin head_id", 32'(bus.head_id), 0);
    chk("unfin count", 32'(bus.count), 1);
    idle(); wb(0, 5'd0, 1'b0); wb(1, 5'd0, 1'b0); tick();
    chk("dual wb finished", 32'(bus.head_finished), 1);
    chk("dual wb exception", 32'(bus.head_exception), 0);
    idle(); bus.commit_head = 1'b1; tick();
    chk("dual commit count", 32'(bus.count), 0);
    chk("dual commit head_id", 32'(bus.head_id), 1);

    // Full with finished head: add+commit -> add dropped
    do_reset();
    for (int i = 0; i < RSZ; i++) begin
      idle(); add(4'(i), 2'(i), i == 0); tick();
    end
    idle(); add(4'd9, 2'd1, 1'b1); bus.commit_head = 1'b1; tick();
    chk("full ac count", 32'(bus.count), 31);
    chk("full ac tail_id", 32'(bus.tail_id), 0);
    chk("full ac head_id", 32'(bus.head_id), 1);
    chk("full ac is_full", 32'(bus.is_full), 0);

    // Wrapped state then flush with concurrent traffic
    do_reset();
    for (int i = 0; i < 20; i++) begin
      idle(); add(4'(i), 2'(i), 1'b1); tick();
    end
    for (int i = 0; i < 20; i++) begin
      idle(); bus.commit_head = 1'b1; tick();
    end
    for (int i = 0; i < 12; i++) begin
      idle(); add(4'(i + 3), 2'(i), 1'b0); tick();
    end
    chk("pre-flush count", 32'(bus.count), 12);
    chk("pre-flush head_id", 32'(bus.head_id), 20);
    chk("pre-flush tail_id", 32'(bus.tail_id), 0);
    idle(); bus.flush = 1'b1; add(4'd1, 2'd1, 1'b1); wb(0, 5'd20, 1'b1);
    bus.commit_head = 1'b1; tick();
    chk("flush head_id", 32'(bus.head_id), 0);
    chk("flush tail_id", 32'(bus.tail_id), 0);
    chk("flush count", 32'(bus.count), 0);
    chk("flush head_valid", 32'(bus.head_valid), 0);
    chk("flush is_empty", 32'(bus.is_empty), 1);
    idle(); tick();
    chk("post-flush count", 32'(bus.count), 0);

    // Steady add+commit across the wrap
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle(); add(4'(i), 2'(i), 1'b1); tick();
    end
    for (int i = 0; i < 40; i++) begin
      idle(); add(4'(i), 2'(i + 1), 1'b1); bus.commit_head = 1'b1; tick();
      chk("steady count", 32'(bus.count), 5);
    end
    chk("steady head_id", 32'(bus.head_id), 8);
    chk("steady tail_id", 32'(bus.tail_id), 13);

    idle(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
